// File: rtl/column_sequencer_if.sv
// rtl/column_sequencer_if.sv - handshake and column-drive bundle of the column sequencer
interface column_sequencer_if #(
    parameter int N_COLUMNS = 8
);
    localparam int CW = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1;

    logic                 enable;
    logic                 slice_start;
    logic                 data_ready;
    logic                 data_req;
    logic [CW-1:0]        data_col;
    logic                 latch;
    logic [N_COLUMNS-1:0] mux_out;
    logic                 busy;
    logic                 overrun;

    modport master (
        output enable, slice_start, data_ready,
        input  data_req, data_col, latch, mux_out, busy, overrun
    );

    modport slave (
        input  enable, slice_start, data_ready,
        output data_req, data_col, latch, mux_out, busy, overrun
    );
endinterface

// File: rtl/column_sequencer.sv
// rtl/column_sequencer.sv - walks the columns of one rotation slice: fetch, latch, drive, blank
module column_sequencer #(
    parameter int N_COLUMNS    = 8,
    parameter int DRIVE_CYCLES = 660,
    parameter int BLANK_CYCLES = 33
) (
    input  logic              clk,
    input  logic              nrst,
    column_sequencer_if.slave bus
);
    localparam int CW      = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1;
    localparam int CNT_MAX = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] DRIVE_LAST = CNTW'(DRIVE_CYCLES - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(N_COLUMNS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        LATCH     = 3'd3,
        DRIVE     = 3'd4,
        BLANK     = 3'd5
    } state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        col, col_nx;
    logic [CNTW-1:0]      cnt, cnt_nx;

    logic                 data_req_q, data_req_nx;
    logic                 latch_q, latch_nx;
    logic [N_COLUMNS-1:0] mux_q, mux_nx;
    logic                 busy_q, busy_nx;
    logic                 overrun_q, overrun_nx;

    // State, column, counter and every output are registered together; reset clears mux at once
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            col        <= '0;
            cnt        <= '0;
            data_req_q <= 1'b0;
            latch_q    <= 1'b0;
            mux_q      <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            col        <= col_nx;
            cnt        <= cnt_nx;
            data_req_q <= data_req_nx;
            latch_q    <= latch_nx;
            mux_q      <= mux_nx;
            busy_q     <= busy_nx;
            overrun_q  <= overrun_nx;
        end
    end

    // Next state: disable beats slice_start, which beats the normal column walk
    always_comb begin
        state_nx = state;
        col_nx   = col;
        cnt_nx   = cnt;
        if (!bus.enable) begin
            state_nx = IDLE;
            col_nx   = '0;
            cnt_nx   = '0;
        end else if (bus.slice_start) begin
            // A new slice always restarts at column 0, even mid-slice or on the last blank cycle
            state_nx = REQ;
            col_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE:      state_nx = IDLE;
                REQ:       state_nx = WAIT_DATA;
                WAIT_DATA: if (bus.data_ready) state_nx = LATCH;
                LATCH: begin
                    state_nx = DRIVE;
                    cnt_nx   = '0;
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt_nx = '0;
                        if (col == COL_LAST) begin
                            state_nx = IDLE;
                            col_nx   = '0;
                        end else begin
                            state_nx = REQ;
                            col_nx   = col + 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    col_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the upcoming state so they appear in the same cycle as that state
    always_comb begin
        data_req_nx = (state_nx == REQ);
        latch_nx    = (state_nx == LATCH);
        busy_nx     = (state_nx != IDLE);
        mux_nx      = '0;
        if (state_nx == DRIVE) begin
            mux_nx = {{(N_COLUMNS-1){1'b0}}, 1'b1} << col_nx;
        end
        overrun_nx  = bus.enable & bus.slice_start & (state != IDLE);
    end

    assign bus.data_req = data_req_q;
    assign bus.data_col = col;
    assign bus.latch    = latch_q;
    assign bus.mux_out  = mux_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_column_sequencer.sv
// tb/tb_column_sequencer.sv - randomized scoreboard bench for column_sequencer
`timescale 1ns/1ps
module tb_column_sequencer;
    localparam int N_COLUMNS    = 8;
    localparam int DRIVE_CYCLES = 660;
    localparam int BLANK_CYCLES = 33;

    localparam int EV_RUN   = 0;
    localparam int EV_OVR   = 1;
    localparam int EV_REQ   = 2;
    localparam int EV_LATCH = 3;
    localparam int EV_BUSYF = 4;

    typedef struct {
        int kind;
        int val;
        int aux;
    } ev_t;

    ev_t exp_q[$];
    int  ready_q[$];
    int  tests = 0;
    int  fails = 0;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    always #5 clk = ~clk;

    column_sequencer_if #(.N_COLUMNS(N_COLUMNS)) bus();

    column_sequencer #(
        .N_COLUMNS(N_COLUMNS),
        .DRIVE_CYCLES(DRIVE_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus)
    );

    function automatic string kname(int k);
        case (k)
            EV_RUN:   return "mux_run";
            EV_OVR:   return "overrun";
            EV_REQ:   return "data_req";
            EV_LATCH: return "latch";
            default:  return "busy_fall";
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected-event model: a slice is a list of per-column events derived from timing rules
    task automatic push(int k, int v, int a);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.aux  = a;
        exp_q.push_back(e);
    endtask

    // d = cycles from data_req until data_ready is sampled; gap = zero-mux cycles before data_req
    task automatic model_column(int c, int d, int gap);
        push(EV_REQ, c, gap);
        push(EV_LATCH, c, d + 1);
        push(EV_RUN, 1 << c, DRIVE_CYCLES);
    endtask

    // d[c] == 0 means data_ready is held high, so WAIT_DATA lasts one cycle
    task automatic model_slice(int first_gap, input int d[N_COLUMNS]);
        for (int c = 0; c < N_COLUMNS; c++) begin
            if (d[c] > 0) ready_q.push_back(d[c]);
            model_column(c, (d[c] > 0) ? d[c] : 1, (c == 0) ? first_gap : BLANK_CYCLES);
        end
        push(EV_BUSYF, 0, BLANK_CYCLES);
    endtask

    task automatic rand_delays(output int d[N_COLUMNS]);
        for (int c = 0; c < N_COLUMNS; c++) d[c] = $urandom_range(1, 6);
    endtask

    task automatic observe(int k, int v, int a);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: got val=%0h aux=%0d, required no event", kname(k), v, a);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.val != v || (e.aux >= 0 && e.aux != a)) begin
            fails++;
            $display("FAIL %s: got %s val=%0h aux=%0d, required %s val=%0h aux=%0d",
                     kname(e.kind), kname(k), v, a, kname(e.kind), e.val, e.aux);
        end
    endtask

    // Responder: answers each data_req with a data_ready pulse after the queued delay
    initial begin : responder
        int d;
        bus.data_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.data_req === 1'b1 && ready_q.size() > 0) begin
                d = ready_q.pop_front();
                repeat (d) @(negedge clk);
                bus.data_ready = 1'b1;
                @(negedge clk);
                bus.data_ready = 1'b0;
            end
        end
    end

    // Monitor: turns DUT outputs into events and checks drive safety every cycle
    int                   cyc          = 0;
    int                   run_len      = 0;
    int                   last_mux_cyc = -1;
    int                   req_cyc      = 0;
    logic [N_COLUMNS-1:0] prev_mux     = '0;
    logic                 prev_busy    = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_mux != '0 && bus.mux_out != prev_mux) observe(EV_RUN, int'(prev_mux), run_len);
        if (bus.mux_out != '0) begin
            check("mux_onehot", 32'($onehot0(bus.mux_out)), 32'd1);
            run_len = (bus.mux_out == prev_mux) ? run_len + 1 : 1;
            check("mux_overdrive", 32'(run_len <= DRIVE_CYCLES), 32'd1);
            last_mux_cyc = cyc;
        end
        if (bus.overrun) observe(EV_OVR, 0, 0);
        if (bus.data_req) begin
            observe(EV_REQ, int'(bus.data_col), (last_mux_cyc < 0) ? -1 : cyc - last_mux_cyc - 1);
            req_cyc = cyc;
        end
        if (bus.latch) observe(EV_LATCH, int'(bus.data_col), cyc - req_cyc);
        if (prev_busy && !bus.busy)
            observe(EV_BUSYF, 0, (last_mux_cyc < 0) ? -1 : cyc - last_mux_cyc - 1);
        prev_mux  = bus.mux_out;
        prev_busy = bus.busy;
    end

    task automatic pulse_start();
        bus.slice_start = 1'b1;
        @(negedge clk);
        bus.slice_start = 1'b0;
    endtask

    task automatic wait_drain(string name, int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            ready_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Returns on the negedge where mux_out has equalled val for k sampled cycles
    task automatic wait_mux_count(logic [N_COLUMNS-1:0] val, int k);
        int n = 0;
        int g = 0;
        while (n < k && g < 20000) begin
            @(negedge clk);
            g++;
            if (bus.mux_out == val) n++;
        end
        check("wait_mux", n, k);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1.5 ms");
        $fatal(1);
    end

    initial begin : driver
        int d[N_COLUMNS];
        int k;
        logic nz;

        bus.enable      = 1'b0;
        bus.slice_start = 1'b0;
        nrst            = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mux_out",  32'(bus.mux_out),  32'd0);
        check("rst_data_req", 32'(bus.data_req), 32'd0);
        check("rst_latch",    32'(bus.latch),    32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_overrun",  32'(bus.overrun),  32'd0);
        check("rst_data_col", 32'(bus.data_col), 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal slice, data_ready three cycles after each request
        for (int c = 0; c < N_COLUMNS; c++) d[c] = 3;
        model_slice(-1, d);
        pulse_start();
        wait_drain("nominal_drain", 8000);

        // data_ready held high: 696-cycle column period
        for (int c = 0; c < N_COLUMNS; c++) d[c] = 0;
        bus.data_ready = 1'b1;
        model_slice(-1, d);
        pulse_start();
        wait_drain("held_ready_drain", 8000);
        bus.data_ready = 1'b0;

        // Abort at drive cycle 100 of column 3
        for (int c = 0; c < 4; c++) begin
            d[c] = $urandom_range(1, 6);
            ready_q.push_back(d[c]);
            if (c < 3) model_column(c, d[c], (c == 0) ? -1 : BLANK_CYCLES);
        end
        push(EV_REQ, 3, BLANK_CYCLES);
        push(EV_LATCH, 3, d[3] + 1);
        push(EV_RUN, 8, 100);
        push(EV_OVR, 0, 0);
        rand_delays(d);
        model_slice(0, d);
        pulse_start();
        wait_mux_count(8'h08, 100);
        pulse_start();
        wait_drain("abort_drain", 12000);

        // enable dropped mid-drive of column 5, start ignored while disabled
        k = $urandom_range(50, 600);
        for (int c = 0; c < 6; c++) begin
            d[c] = $urandom_range(1, 6);
            ready_q.push_back(d[c]);
            if (c < 5) model_column(c, d[c], (c == 0) ? -1 : BLANK_CYCLES);
        end
        push(EV_REQ, 5, BLANK_CYCLES);
        push(EV_LATCH, 5, d[5] + 1);
        push(EV_RUN, 32, k);
        push(EV_BUSYF, 0, 0);
        pulse_start();
        wait_mux_count(8'h20, k);
        bus.enable = 1'b0;
        @(negedge clk);
        check("disable_mux_off", 32'(bus.mux_out), 32'd0);
        check("disable_busy",    32'(bus.busy),    32'd0);
        pulse_start();
        repeat (20) @(negedge clk);
        check("disabled_start_busy", 32'(bus.busy), 32'd0);
        wait_drain("disable_drain", 10);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        rand_delays(d);
        model_slice(-1, d);
        pulse_start();
        wait_drain("reenable_drain", 8000);

        // data_ready withheld 10000 cycles on column 0
        rand_delays(d);
        d[0] = 10000;
        model_slice(-1, d);
        pulse_start();
        nz = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (bus.mux_out != '0) nz = 1'b1;
        end
        check("mux_zero_while_waiting", 32'(nz), 32'd0);
        wait_drain("withhold_drain", 8000);

        // slice_start on the last blank cycle of the last column restarts at column 0
        rand_delays(d);
        for (int c = 0; c < N_COLUMNS; c++) begin
            ready_q.push_back(d[c]);
            model_column(c, d[c], (c == 0) ? -1 : BLANK_CYCLES);
        end
        push(EV_OVR, 0, 0);
        rand_delays(d);
        model_slice(BLANK_CYCLES, d);
        pulse_start();
        wait_mux_count(8'h80, DRIVE_CYCLES);
        repeat (BLANK_CYCLES) @(negedge clk);
        pulse_start();
        wait_drain("last_blank_restart_drain", 8000);

        // Asynchronous reset mid-drive of column 2
        k = $urandom_range(20, 600);
        for (int c = 0; c < 3; c++) begin
            d[c] = $urandom_range(1, 6);
            ready_q.push_back(d[c]);
            if (c < 2) model_column(c, d[c], (c == 0) ? -1 : BLANK_CYCLES);
        end
        push(EV_REQ, 2, BLANK_CYCLES);
        push(EV_LATCH, 2, d[2] + 1);
        push(EV_RUN, 4, k);
        push(EV_BUSYF, 0, 0);
        pulse_start();
        wait_mux_count(8'h04, k);
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_mux_out",  32'(bus.mux_out),  32'd0);
        check("async_rst_busy",     32'(bus.busy),     32'd0);
        check("async_rst_data_col", 32'(bus.data_col), 32'd0);
        check("async_rst_latch",    32'(bus.latch),    32'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        wait_drain("reset_drain", 10);

        check("final_ready_queue_empty", ready_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
